// File: rtl/int_issue_queue.sv
// int_issue_queue: integer reservation station with CDB snoop and oldest-ready issue.
// Collapsing queue: entry 0 is the oldest, valid entries occupy slots 0..count-1.
// Optional macro INT_RS_FAST_WAKEUP_EN: select also treats current-cycle CDB tag
// matches as ready and forwards cdb_data, giving wakeup-to-issue in one cycle.

package int_issue_queue_pkg;

    localparam int unsigned CDB_TAG_W  = 6;
    localparam int unsigned CDB_DATA_W = 32;

    // Common data bus broadcast driven by the execution unit.
    typedef struct packed {
        logic                  cdb_valid;
        logic [CDB_TAG_W-1:0]  cdb_tag;
        logic [CDB_DATA_W-1:0] cdb_data;
    } cdb_bus;

endpackage

module int_issue_queue
    import int_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dispatch_en,
    input  logic [6:0]                 disp_opcode,
    input  logic [2:0]                 disp_funct3,
    input  logic [6:0]                 disp_funct7,
    input  logic [DATA_W-1:0]          disp_rs1_data,
    input  logic [TAG_W-1:0]           disp_rs1_tag,
    input  logic                       disp_rs1_rdy,
    input  logic [DATA_W-1:0]          disp_rs2_data,
    input  logic [TAG_W-1:0]           disp_rs2_tag,
    input  logic                       disp_rs2_rdy,
    input  logic [TAG_W-1:0]           disp_rd_tag,
    input  cdb_bus                     cdb_in,
    input  logic                       issue_stall,
    input  logic                       flush,
    output logic                       issue_int,
    output logic [6:0]                 Opcode,
    output logic [2:0]                 Funct3,
    output logic [6:0]                 Funct7,
    output logic [DATA_W-1:0]          RS1,
    output logic [DATA_W-1:0]          RS2,
    output logic [TAG_W-1:0]           RD_Tag,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    // Entry storage
    logic [6:0]        opcode_q [DEPTH];
    logic [6:0]        opcode_d [DEPTH];
    logic [2:0]        funct3_q [DEPTH];
    logic [2:0]        funct3_d [DEPTH];
    logic [6:0]        funct7_q [DEPTH];
    logic [6:0]        funct7_d [DEPTH];
    logic [TAG_W-1:0]  rd_tag_q [DEPTH];
    logic [TAG_W-1:0]  rd_tag_d [DEPTH];
    logic [DATA_W-1:0] data1_q  [DEPTH];
    logic [DATA_W-1:0] data1_d  [DEPTH];
    logic [TAG_W-1:0]  tag1_q   [DEPTH];
    logic [TAG_W-1:0]  tag1_d   [DEPTH];
    logic              rdy1_q   [DEPTH];
    logic              rdy1_d   [DEPTH];
    logic [DATA_W-1:0] data2_q  [DEPTH];
    logic [DATA_W-1:0] data2_d  [DEPTH];
    logic [TAG_W-1:0]  tag2_q   [DEPTH];
    logic [TAG_W-1:0]  tag2_d   [DEPTH];
    logic              rdy2_q   [DEPTH];
    logic              rdy2_d   [DEPTH];

    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;

    // Issue output registers
    logic              issue_q, issue_d;
    logic [6:0]        out_opcode_q, out_opcode_d;
    logic [2:0]        out_funct3_q, out_funct3_d;
    logic [6:0]        out_funct7_q, out_funct7_d;
    logic [DATA_W-1:0] out_rs1_q, out_rs1_d;
    logic [DATA_W-1:0] out_rs2_q, out_rs2_d;
    logic [TAG_W-1:0]  out_rd_tag_q, out_rd_tag_d;

    // CDB fields resized to the queue's widths
    logic              cdb_vld_c;
    logic [TAG_W-1:0]  cdb_tag_c;
    logic [DATA_W-1:0] cdb_data_c;

    logic              wake1_c     [DEPTH];
    logic              wake2_c     [DEPTH];
    logic              sel_rdy1_c  [DEPTH];
    logic              sel_rdy2_c  [DEPTH];
    logic [DATA_W-1:0] sel_data1_c [DEPTH];
    logic [DATA_W-1:0] sel_data2_c [DEPTH];

    logic              found_c;
    logic [IDX_W-1:0]  sel_idx_c;
    logic              issue_c;
    logic              disp_acc_c;
    logic              disp_hit1_c;
    logic              disp_hit2_c;

    assign cdb_vld_c  = cdb_in.cdb_valid;
    assign cdb_tag_c  = TAG_W'(cdb_in.cdb_tag);
    assign cdb_data_c = DATA_W'(cdb_in.cdb_data);

    // Per-entry CDB tag match (tag 0 never matches) and the readiness seen by select
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            wake1_c[i] = cdb_vld_c && !rdy1_q[i] && (tag1_q[i] == cdb_tag_c) && (tag1_q[i] != '0);
            wake2_c[i] = cdb_vld_c && !rdy2_q[i] && (tag2_q[i] == cdb_tag_c) && (tag2_q[i] != '0);
`ifdef INT_RS_FAST_WAKEUP_EN
            sel_rdy1_c[i]  = rdy1_q[i] | wake1_c[i];
            sel_rdy2_c[i]  = rdy2_q[i] | wake2_c[i];
            sel_data1_c[i] = wake1_c[i] ? cdb_data_c : data1_q[i];
            sel_data2_c[i] = wake2_c[i] ? cdb_data_c : data2_q[i];
`else
            sel_rdy1_c[i]  = rdy1_q[i];
            sel_rdy2_c[i]  = rdy2_q[i];
            sel_data1_c[i] = data1_q[i];
            sel_data2_c[i] = data2_q[i];
`endif
        end
    end

    // Oldest-ready select: scan downward so the lowest index wins
    always_comb begin
        found_c   = 1'b0;
        sel_idx_c = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if ((i < int'(count_q)) && sel_rdy1_c[i] && sel_rdy2_c[i]) begin
                found_c   = 1'b1;
                sel_idx_c = IDX_W'(i);
            end
        end
    end

    assign issue_c     = found_c && !issue_stall && !flush;
    assign disp_acc_c  = dispatch_en && !full_q && !flush;
    assign disp_hit1_c = cdb_vld_c && (disp_rs1_tag == cdb_tag_c) && (disp_rs1_tag != '0);
    assign disp_hit2_c = cdb_vld_c && (disp_rs2_tag == cdb_tag_c) && (disp_rs2_tag != '0);

    // Next queue contents: collapse over the issued slot, apply wakeup, append dispatch
    always_comb begin
        int src;
        int slot;
        for (int j = 0; j < int'(DEPTH); j++) begin
            opcode_d[j] = opcode_q[j];
            funct3_d[j] = funct3_q[j];
            funct7_d[j] = funct7_q[j];
            rd_tag_d[j] = rd_tag_q[j];
            data1_d[j]  = data1_q[j];
            tag1_d[j]   = tag1_q[j];
            rdy1_d[j]   = rdy1_q[j];
            data2_d[j]  = data2_q[j];
            tag2_d[j]   = tag2_q[j];
            rdy2_d[j]   = rdy2_q[j];
        end
        src  = 0;
        slot = 0;
        count_d = count_q;

        for (int j = 0; j < int'(DEPTH); j++) begin
            src = (issue_c && (j >= int'(sel_idx_c))) ? j + 1 : j;
            if (src < int'(count_q)) begin
                opcode_d[j] = opcode_q[src];
                funct3_d[j] = funct3_q[src];
                funct7_d[j] = funct7_q[src];
                rd_tag_d[j] = rd_tag_q[src];
                tag1_d[j]   = tag1_q[src];
                tag2_d[j]   = tag2_q[src];
                rdy1_d[j]   = rdy1_q[src] | wake1_c[src];
                rdy2_d[j]   = rdy2_q[src] | wake2_c[src];
                data1_d[j]  = wake1_c[src] ? cdb_data_c : data1_q[src];
                data2_d[j]  = wake2_c[src] ? cdb_data_c : data2_q[src];
            end
        end

        slot = int'(count_q) - (issue_c ? 1 : 0);
        if (disp_acc_c) begin
            opcode_d[slot] = disp_opcode;
            funct3_d[slot] = disp_funct3;
            funct7_d[slot] = disp_funct7;
            rd_tag_d[slot] = disp_rd_tag;
            tag1_d[slot]   = disp_rs1_tag;
            tag2_d[slot]   = disp_rs2_tag;
            rdy1_d[slot]   = disp_rs1_rdy | disp_hit1_c;
            rdy2_d[slot]   = disp_rs2_rdy | disp_hit2_c;
            data1_d[slot]  = (!disp_rs1_rdy && disp_hit1_c) ? cdb_data_c : disp_rs1_data;
            data2_d[slot]  = (!disp_rs2_rdy && disp_hit2_c) ? cdb_data_c : disp_rs2_data;
        end

        if (flush) begin
            count_d = '0;
        end else begin
            count_d = CNT_W'(int'(count_q) + (disp_acc_c ? 1 : 0) - (issue_c ? 1 : 0));
        end
        full_d = (count_d == CNT_W'(DEPTH));
    end

    // Next issue outputs: data registers hold unless an op is issued
    always_comb begin
        issue_d      = issue_c;
        out_opcode_d = out_opcode_q;
        out_funct3_d = out_funct3_q;
        out_funct7_d = out_funct7_q;
        out_rs1_d    = out_rs1_q;
        out_rs2_d    = out_rs2_q;
        out_rd_tag_d = out_rd_tag_q;
        if (issue_c) begin
            out_opcode_d = opcode_q[sel_idx_c];
            out_funct3_d = funct3_q[sel_idx_c];
            out_funct7_d = funct7_q[sel_idx_c];
            out_rs1_d    = sel_data1_c[sel_idx_c];
            out_rs2_d    = sel_data2_c[sel_idx_c];
            out_rd_tag_d = rd_tag_q[sel_idx_c];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                opcode_q[i] <= '0;
                funct3_q[i] <= '0;
                funct7_q[i] <= '0;
                rd_tag_q[i] <= '0;
                data1_q[i]  <= '0;
                tag1_q[i]   <= '0;
                rdy1_q[i]   <= 1'b0;
                data2_q[i]  <= '0;
                tag2_q[i]   <= '0;
                rdy2_q[i]   <= 1'b0;
            end
            count_q      <= '0;
            full_q       <= 1'b0;
            issue_q      <= 1'b0;
            out_opcode_q <= '0;
            out_funct3_q <= '0;
            out_funct7_q <= '0;
            out_rs1_q    <= '0;
            out_rs2_q    <= '0;
            out_rd_tag_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                opcode_q[i] <= opcode_d[i];
                funct3_q[i] <= funct3_d[i];
                funct7_q[i] <= funct7_d[i];
                rd_tag_q[i] <= rd_tag_d[i];
                data1_q[i]  <= data1_d[i];
                tag1_q[i]   <= tag1_d[i];
                rdy1_q[i]   <= rdy1_d[i];
                data2_q[i]  <= data2_d[i];
                tag2_q[i]   <= tag2_d[i];
                rdy2_q[i]   <= rdy2_d[i];
            end
            count_q      <= count_d;
            full_q       <= full_d;
            issue_q      <= issue_d;
            out_opcode_q <= out_opcode_d;
            out_funct3_q <= out_funct3_d;
            out_funct7_q <= out_funct7_d;
            out_rs1_q    <= out_rs1_d;
            out_rs2_q    <= out_rs2_d;
            out_rd_tag_q <= out_rd_tag_d;
        end
    end

    assign issue_int = issue_q;
    assign Opcode    = out_opcode_q;
    assign Funct3    = out_funct3_q;
    assign Funct7    = out_funct7_q;
    assign RS1       = out_rs1_q;
    assign RS2       = out_rs2_q;
    assign RD_Tag    = out_rd_tag_q;
    assign full      = full_q;
    assign count     = count_q;

endmodule

// File: tb/tb_int_issue_queue.sv
// Scoreboard bench for int_issue_queue: stimulus pushes expected issues with
// their expected cycle; a negedge monitor pops and compares each issue pulse.
module tb_int_issue_queue;
    import int_issue_queue_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned TAG_W  = 6;
    localparam int unsigned DATA_W = 32;
`ifdef INT_RS_FAST_WAKEUP_EN
    localparam int WAKE_LAT = 1;
`else
    localparam int WAKE_LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              dispatch_en;
    logic [6:0]        disp_opcode;
    logic [2:0]        disp_funct3;
    logic [6:0]        disp_funct7;
    logic [DATA_W-1:0] disp_rs1_data;
    logic [TAG_W-1:0]  disp_rs1_tag;
    logic              disp_rs1_rdy;
    logic [DATA_W-1:0] disp_rs2_data;
    logic [TAG_W-1:0]  disp_rs2_tag;
    logic              disp_rs2_rdy;
    logic [TAG_W-1:0]  disp_rd_tag;
    cdb_bus            cdb_in;
    logic              issue_stall;
    logic              flush;
    logic              issue_int;
    logic [6:0]        Opcode;
    logic [2:0]        Funct3;
    logic [6:0]        Funct7;
    logic [DATA_W-1:0] RS1;
    logic [DATA_W-1:0] RS2;
    logic [TAG_W-1:0]  RD_Tag;
    logic              full;
    logic [2:0]        count;

    int cyc    = 0;
    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [5:0]  rd;
        int          at;
    } exp_t;
    exp_t exp_q[$];

    int_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .dispatch_en(dispatch_en),
        .disp_opcode(disp_opcode), .disp_funct3(disp_funct3), .disp_funct7(disp_funct7),
        .disp_rs1_data(disp_rs1_data), .disp_rs1_tag(disp_rs1_tag), .disp_rs1_rdy(disp_rs1_rdy),
        .disp_rs2_data(disp_rs2_data), .disp_rs2_tag(disp_rs2_tag), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rd_tag(disp_rd_tag), .cdb_in(cdb_in), .issue_stall(issue_stall), .flush(flush),
        .issue_int(issue_int), .Opcode(Opcode), .Funct3(Funct3), .Funct7(Funct7),
        .RS1(RS1), .RS2(RS2), .RD_Tag(RD_Tag), .full(full), .count(count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, req);
        end
    endtask

    // Monitor: every issue pulse must match the oldest expected issue, at its cycle
    always @(negedge clk) begin
        exp_t e;
        if (!rst && issue_int) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_issue cyc=%0d got rd_tag=%0d expected no issue", cyc, RD_Tag);
            end else begin
                e = exp_q.pop_front();
                chk("issue_fields", 96'({Opcode, Funct3, Funct7, RS1, RS2, RD_Tag}),
                    96'({e.op, e.f3, e.f7, e.rs1, e.rs2, e.rd}));
                chk("issue_cycle", 96'(cyc), 96'(e.at));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dispatch_en = 1'b0;
        cdb_in      = '0;
        flush       = 1'b0;
    endtask

    task automatic disp(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] d1, input logic [5:0] t1, input logic r1,
                        input logic [31:0] d2, input logic [5:0] t2, input logic r2,
                        input logic [5:0] rd);
        dispatch_en   = 1'b1;
        disp_opcode   = op;
        disp_funct3   = f3;
        disp_funct7   = f7;
        disp_rs1_data = d1;
        disp_rs1_tag  = t1;
        disp_rs1_rdy  = r1;
        disp_rs2_data = d2;
        disp_rs2_tag  = t2;
        disp_rs2_rdy  = r2;
        disp_rd_tag   = rd;
    endtask

    task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
        cdb_in.cdb_valid = 1'b1;
        cdb_in.cdb_tag   = tag;
        cdb_in.cdb_data  = data;
    endtask

    task automatic expect_issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [5:0] rd, input int lat);
        exp_t e;
        e.op = op; e.f3 = f3; e.f7 = f7; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.at = cyc + lat;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        issue_stall = 1'b0;
        disp(7'h0, 3'h0, 7'h0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 6'd0);
        idle();
        repeat (2) step();
        @(negedge clk);
        chk("rst_issue_int", 96'(issue_int), 96'(0));
        chk("rst_count",     96'(count),     96'(0));
        chk("rst_full",      96'(full),      96'(0));
        chk("rst_opcode",    96'({Opcode, Funct3, Funct7}), 96'(0));
        chk("rst_rs1",       96'(RS1),       96'(0));
        chk("rst_rs2",       96'(RS2),       96'(0));
        chk("rst_rd_tag",    96'(RD_Tag),    96'(0));
        step();
        rst = 1'b0;
        step();

        // Both sources ready: issue two cycles after dispatch
        disp(7'h33, 3'h0, 7'h00, 32'd5, 6'd0, 1'b1, 32'd7, 6'd0, 1'b1, 6'd3);
        expect_issue(7'h33, 3'h0, 7'h00, 32'd5, 32'd7, 6'd3, 2);
        step(); idle();
        repeat (3) step();
        @(negedge clk);
        chk("t1_count_drained", 96'(count), 96'(0));

        // rs1 waits on tag 9, woken by a later CDB broadcast
        step();
        disp(7'h33, 3'h0, 7'h20, 32'h0, 6'd9, 1'b0, 32'd11, 6'd0, 1'b1, 6'd10);
        step(); idle();
        @(negedge clk);
        chk("t2_waiting_count", 96'(count), 96'(1));
        step();
        cdb(6'd9, 32'hDEAD);
        expect_issue(7'h33, 3'h0, 7'h20, 32'hDEAD, 32'd11, 6'd10, WAKE_LAT);
        step(); idle();
        repeat (3) step();

        // rs2 tag broadcast on the CDB in the dispatch cycle itself
        disp(7'h13, 3'h1, 7'h00, 32'h100, 6'd0, 1'b1, 32'h0, 6'd4, 1'b0, 6'd22);
        cdb(6'd4, 32'hBEEF);
        expect_issue(7'h13, 3'h1, 7'h00, 32'h100, 32'hBEEF, 6'd22, 2);
        step(); idle();
        repeat (3) step();

        // Fill under stall, drop a dispatch while full, then drain in order
        issue_stall = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            disp(7'h33, 3'h0, 7'h00, 32'(k), 6'd0, 1'b1, 32'(k + 100), 6'd0, 1'b1, 6'(k));
            step();
        end
        idle();
        @(negedge clk);
        chk("t4_full_count", 96'(count), 96'(4));
        chk("t4_full_flag",  96'(full),  96'(1));
        step();
        disp(7'h33, 3'h0, 7'h00, 32'd5, 6'd0, 1'b1, 32'd105, 6'd0, 1'b1, 6'd5);
        step(); idle();
        @(negedge clk);
        chk("t4_dropped_count", 96'(count), 96'(4));
        step();
        issue_stall = 1'b0;
        for (int k = 1; k <= 4; k++)
            expect_issue(7'h33, 3'h0, 7'h00, 32'(k), 32'(k + 100), 6'(k), k);
        repeat (6) step();
        @(negedge clk);
        chk("t4_drained_full", 96'({full, count}), 96'(0));

        // Younger ready entry bypasses an older waiting one
        step();
        disp(7'h33, 3'h0, 7'h00, 32'h0, 6'd8, 1'b0, 32'h55, 6'd0, 1'b1, 6'd20);
        step();
        disp(7'h33, 3'h2, 7'h00, 32'h21, 6'd0, 1'b1, 32'h22, 6'd0, 1'b1, 6'd21);
        expect_issue(7'h33, 3'h2, 7'h00, 32'h21, 32'h22, 6'd21, 2);
        step(); idle();
        step();
        cdb(6'd8, 32'h88);
        expect_issue(7'h33, 3'h0, 7'h00, 32'h88, 32'h55, 6'd20, WAKE_LAT);
        step(); idle();
        repeat (3) step();

        // Issue, shift, wakeup of the shifted entry and dispatch in one cycle
        issue_stall = 1'b1;
        disp(7'h33, 3'h0, 7'h00, 32'h30, 6'd0, 1'b1, 32'h31, 6'd0, 1'b1, 6'd30);
        step();
        disp(7'h33, 3'h0, 7'h00, 32'h0, 6'd12, 1'b0, 32'h41, 6'd0, 1'b1, 6'd31);
        step();
        issue_stall = 1'b0;
        cdb(6'd12, 32'h1200);
        disp(7'h33, 3'h0, 7'h00, 32'h50, 6'd0, 1'b1, 32'h51, 6'd0, 1'b1, 6'd32);
        expect_issue(7'h33, 3'h0, 7'h00, 32'h30, 32'h31, 6'd30, 1);
        expect_issue(7'h33, 3'h0, 7'h00, 32'h1200, 32'h41, 6'd31, 2);
        expect_issue(7'h33, 3'h0, 7'h00, 32'h50, 32'h51, 6'd32, 3);
        step(); idle();
        repeat (4) step();
        @(negedge clk);
        chk("t6_count_drained", 96'(count), 96'(0));

        // Flush with a concurrent dispatch; later tag match must not issue
        step();
        issue_stall = 1'b1;
        disp(7'h33, 3'h0, 7'h00, 32'h0, 6'd13, 1'b0, 32'h1, 6'd0, 1'b1, 6'd40);
        step();
        disp(7'h33, 3'h0, 7'h00, 32'h0, 6'd13, 1'b0, 32'h1, 6'd0, 1'b1, 6'd41);
        step();
        idle();
        @(negedge clk);
        chk("t7_pre_flush_count", 96'(count), 96'(2));
        step();
        issue_stall = 1'b0;
        flush = 1'b1;
        disp(7'h33, 3'h0, 7'h00, 32'h2, 6'd0, 1'b1, 32'h3, 6'd0, 1'b1, 6'd42);
        step(); idle();
        @(negedge clk);
        chk("t7_flush_count", 96'(count),     96'(0));
        chk("t7_flush_issue", 96'(issue_int), 96'(0));
        step();
        cdb(6'd13, 32'h77);
        step(); idle();
        repeat (3) step();
        @(negedge clk);
        chk("t7_post_cdb_count", 96'(count), 96'(0));

        // Reset with ready entries queued: nothing issues afterwards
        step();
        issue_stall = 1'b1;
        disp(7'h33, 3'h0, 7'h00, 32'h9, 6'd0, 1'b1, 32'h9, 6'd0, 1'b1, 6'd50);
        step();
        disp(7'h33, 3'h0, 7'h00, 32'h9, 6'd0, 1'b1, 32'h9, 6'd0, 1'b1, 6'd51);
        step(); idle();
        rst = 1'b1;
        issue_stall = 1'b0;
        step();
        rst = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("t8_rst_count", 96'(count),     96'(0));
        chk("t8_rst_issue", 96'(issue_int), 96'(0));

        step();
        chk("pending_issues", 96'(exp_q.size()), 96'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
